// File: rtl/mvm_engine.sv
// Time-multiplexed matrix-vector engine: y = sat(round((W*x) >> QM)) over NLANE MAC lanes.
// Define MVM_BIAS_ADD_EN to add the biasVector port and per-row bias before rounding.
module mvm_engine #(
    parameter int unsigned NROW  = 16,
    parameter int unsigned NCOL  = 16,
    parameter int unsigned QN    = 6,
    parameter int unsigned QM    = 11,
    parameter int unsigned NLANE = 4,
    localparam int unsigned BITWIDTH      = QN + QM + 1,
    localparam int unsigned RPL           = NROW / NLANE,
    localparam int unsigned ADDR_BITWIDTH = $clog2(NCOL),
    localparam int unsigned MUX_BITWIDTH  = (RPL > 1) ? $clog2(RPL) : 1,
    localparam int unsigned ACC_BITWIDTH  = 2 * BITWIDTH + ADDR_BITWIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NROW*BITWIDTH-1:0] weightCol,
    input  logic [BITWIDTH-1:0]      inputElem,
`ifdef MVM_BIAS_ADD_EN
    input  logic [NROW*BITWIDTH-1:0] biasVector,
`endif
    output logic [ADDR_BITWIDTH-1:0] colAddress,
    output logic [MUX_BITWIDTH-1:0]  rowMux,
    output logic                     busy,
    output logic                     dataReady,
    output logic                     overflow,
    output logic [NROW*BITWIDTH-1:0] outputVector
);

    localparam int unsigned ROW_BITWIDTH  = (NROW > 1) ? $clog2(NROW) : 1;
    localparam int unsigned PROD_BITWIDTH = 2 * BITWIDTH;
    localparam int unsigned SUM_BITWIDTH  = ACC_BITWIDTH + 1;

    localparam logic [ADDR_BITWIDTH-1:0]       COL_LAST = ADDR_BITWIDTH'(NCOL - 1);
    localparam logic [MUX_BITWIDTH-1:0]        MUX_LAST = MUX_BITWIDTH'(RPL - 1);
    localparam logic signed [SUM_BITWIDTH-1:0] HALF_LSB = SUM_BITWIDTH'(1) << (QM - 1);
    localparam logic signed [SUM_BITWIDTH-1:0] SAT_MAX  =
        (SUM_BITWIDTH'(1) << (BITWIDTH - 1)) - SUM_BITWIDTH'(1);
    localparam logic signed [SUM_BITWIDTH-1:0] SAT_MIN  = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                         state;
    logic signed [ACC_BITWIDTH-1:0] acc      [NLANE];
    logic signed [ACC_BITWIDTH-1:0] acc_next [NLANE];
    logic        [BITWIDTH-1:0]     y_fin    [NLANE];
    logic        [ROW_BITWIDTH-1:0] row_idx  [NLANE];
    logic        [NLANE-1:0]        clip;
    logic        [BITWIDTH-1:0]     staging  [NROW];
    logic        [BITWIDTH-1:0]     w_row    [NROW];
`ifdef MVM_BIAS_ADD_EN
    logic        [BITWIDTH-1:0]     b_row    [NROW];
`endif
    logic                           ovf_run;
    logic signed [BITWIDTH-1:0]     x_s;

    assign x_s = inputElem;

    // Unpack the flat column bus into per-row words.
    for (genvar r = 0; r < NROW; r++) begin : g_row
        assign w_row[r] = weightCol[r*BITWIDTH +: BITWIDTH];
`ifdef MVM_BIAS_ADD_EN
        assign b_row[r] = biasVector[r*BITWIDTH +: BITWIDTH];
`endif
    end

    // Per-lane MAC, rounding and saturation; lane l serves row l*RPL + rowMux.
    for (genvar l = 0; l < NLANE; l++) begin : g_lane
        logic        [ROW_BITWIDTH-1:0]  row;
        logic signed [BITWIDTH-1:0]      w;
        logic signed [PROD_BITWIDTH-1:0] prod;
        logic signed [ACC_BITWIDTH-1:0]  acc_nx;
        logic signed [SUM_BITWIDTH-1:0]  s;
        logic signed [SUM_BITWIDTH-1:0]  rnd;
        logic signed [SUM_BITWIDTH-1:0]  q;
        logic        [BITWIDTH-1:0]      y;
        logic                            clipped;

        always_comb begin
            row     = ROW_BITWIDTH'(l * RPL) + ROW_BITWIDTH'(rowMux);
            w       = w_row[row];
            prod    = w * x_s;
            acc_nx  = (colAddress == '0) ? ACC_BITWIDTH'(prod)
                                         : acc[l] + ACC_BITWIDTH'(prod);
            s       = SUM_BITWIDTH'(acc_nx);
`ifdef MVM_BIAS_ADD_EN
            s       = s + (SUM_BITWIDTH'($signed(b_row[row])) <<< QM);
`endif
            rnd     = s + HALF_LSB;
            q       = rnd >>> QM;
            y       = q[BITWIDTH-1:0];
            clipped = 1'b0;
            if (q > SAT_MAX) begin
                y       = SAT_MAX[BITWIDTH-1:0];
                clipped = 1'b1;
            end else if (q < SAT_MIN) begin
                y       = SAT_MIN[BITWIDTH-1:0];
                clipped = 1'b1;
            end
        end

        assign row_idx[l]  = row;
        assign acc_next[l] = acc_nx;
        assign y_fin[l]    = y;
        assign clip[l]     = clipped;
    end

    // Control FSM with registered outputs, accumulators and result staging.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            colAddress   <= '0;
            rowMux       <= '0;
            busy         <= 1'b0;
            dataReady    <= 1'b0;
            overflow     <= 1'b0;
            outputVector <= '0;
            ovf_run      <= 1'b0;
            for (int unsigned l = 0; l < NLANE; l++) acc[l] <= '0;
            for (int unsigned r = 0; r < NROW; r++) staging[r] <= '0;
        end else begin
            dataReady <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= CALC;
                        busy       <= 1'b1;
                        colAddress <= '0;
                        rowMux     <= '0;
                        ovf_run    <= 1'b0;
                    end
                end
                CALC: begin
                    colAddress <= colAddress + ADDR_BITWIDTH'(1);
                    for (int unsigned l = 0; l < NLANE; l++) acc[l] <= acc_next[l];
                    if (colAddress == COL_LAST) begin
                        rowMux  <= rowMux + MUX_BITWIDTH'(1);
                        ovf_run <= ovf_run | (|clip);
                        for (int unsigned l = 0; l < NLANE; l++) staging[row_idx[l]] <= y_fin[l];
                        if (rowMux == MUX_LAST) begin
                            // Final group bypasses staging so the whole vector lands at once.
                            state     <= DONE;
                            busy      <= 1'b0;
                            dataReady <= 1'b1;
                            rowMux    <= '0;
                            overflow  <= ovf_run | (|clip);
                            for (int unsigned r = 0; r < NROW; r++) begin
                                if ((r % RPL) == (RPL - 1))
                                    outputVector[r*BITWIDTH +: BITWIDTH] <= y_fin[r / RPL];
                                else
                                    outputVector[r*BITWIDTH +: BITWIDTH] <= staging[r];
                            end
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state      <= CALC;
                        busy       <= 1'b1;
                        colAddress <= '0;
                        rowMux     <= '0;
                        ovf_run    <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_engine.sv
// Directed bench for mvm_engine with a scoreboard of expected result vectors.
module tb_mvm_engine;

    localparam int NROW  = 16;
    localparam int NCOL  = 16;
    localparam int QN    = 6;
    localparam int QM    = 11;
    localparam int NLANE = 4;
    localparam int BW    = QN + QM + 1;
    localparam int RPL   = NROW / NLANE;
    localparam int AW    = 4;
    localparam int MW    = 2;
    localparam int VW    = NROW * BW;
    localparam int LAT   = NCOL * RPL + 1;
    localparam longint MAXV = (longint'(1) <<< (BW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (BW - 1));

    typedef struct packed {
        logic [VW-1:0] vec;
        logic          ovf;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [VW-1:0] weightCol;
    logic [BW-1:0] inputElem;
    logic [VW-1:0] biasVector;
    logic [AW-1:0] colAddress;
    logic [MW-1:0] rowMux;
    logic          busy;
    logic          dataReady;
    logic          overflow;
    logic [VW-1:0] outputVector;

    int   wmat [NROW][NCOL];
    int   xvec [NCOL];
    int   bvec [NROW];
    exp_t sbq [$];
    int   n_assert;
    int   n_fail;
    int   dr_cnt;

    mvm_engine dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .weightCol    (weightCol),
        .inputElem    (inputElem),
`ifdef MVM_BIAS_ADD_EN
        .biasVector   (biasVector),
`endif
        .colAddress   (colAddress),
        .rowMux       (rowMux),
        .busy         (busy),
        .dataReady    (dataReady),
        .overflow     (overflow),
        .outputVector (outputVector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational weight/input memories addressed by colAddress.
    always_comb begin
        weightCol  = '0;
        biasVector = '0;
        for (int r = 0; r < NROW; r++) begin
            weightCol[r*BW +: BW]  = BW'(wmat[r][colAddress]);
            biasVector[r*BW +: BW] = BW'(bvec[r]);
        end
        inputElem = BW'(xvec[colAddress]);
    end

    always @(negedge clk) if (dataReady) dr_cnt <= dr_cnt + 1;

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model();
        exp_t   e;
        longint s;
        longint q;
        e.vec = '0;
        e.ovf = 1'b0;
        for (int r = 0; r < NROW; r++) begin
            s = 0;
            for (int c = 0; c < NCOL; c++) s += longint'(wmat[r][c]) * longint'(xvec[c]);
`ifdef MVM_BIAS_ADD_EN
            s += longint'(bvec[r]) * (longint'(1) <<< QM);
`endif
            q = (s + (longint'(1) <<< (QM - 1))) >>> QM;
            if (q > MAXV) begin
                q = MAXV;
                e.ovf = 1'b1;
            end else if (q < MINV) begin
                q = MINV;
                e.ovf = 1'b1;
            end
            e.vec[r*BW +: BW] = q[BW-1:0];
        end
        return e;
    endfunction

    task automatic fill(input int wv, input int xv);
        for (int r = 0; r < NROW; r++)
            for (int c = 0; c < NCOL; c++) wmat[r][c] = wv;
        for (int c = 0; c < NCOL; c++) xvec[c] = xv;
    endtask

    task automatic fill_identity();
        for (int r = 0; r < NROW; r++)
            for (int c = 0; c < NCOL; c++) wmat[r][c] = (r == c) ? 2048 : 0;
        for (int c = 0; c < NCOL; c++) xvec[c] = c * 100 - 700;
    endtask

    // One start pulse from IDLE; checks latency, busy length, result and pulse width.
    task automatic run_and_check(input string tag);
        exp_t e;
        int   n;
        int   nb;
        sbq.push_back(model());
        start = 1'b1;
        n  = 0;
        nb = 0;
        do begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (busy) nb++;
        end while (!dataReady && n < 200);
        chk({tag, "_latency"}, VW'(n), VW'(LAT));
        chk({tag, "_busy_cycles"}, VW'(nb), VW'(LAT - 1));
        e = sbq.pop_front();
        chk({tag, "_vector"}, outputVector, e.vec);
        chk({tag, "_overflow"}, VW'(overflow), VW'(e.ovf));
        @(negedge clk);
        chk({tag, "_pulse_idle"}, VW'({busy, dataReady}), '0);
    endtask

    initial begin
        exp_t e;
        int   n;
        int   d0;
        reset = 1'b0;
        start = 1'b0;
        fill(0, 0);
        for (int r = 0; r < NROW; r++) bvec[r] = 0;
        repeat (3) @(negedge clk);
        chk("reset_vector", outputVector, '0);
        chk("reset_flags", VW'({busy, dataReady, overflow}), '0);
        chk("reset_addr", VW'({rowMux, colAddress}), '0);
        reset = 1'b1;
        @(negedge clk);

        fill(2048, 2048);
        run_and_check("ones");
        chk("ones_row0", VW'(outputVector[0 +: BW]), VW'(32768));

        fill(16384, 2048);
        run_and_check("sat_pos");
        chk("sat_pos_row5", VW'(outputVector[5*BW +: BW]), VW'(18'h1FFFF));

        fill(-16384, 2048);
        run_and_check("sat_neg");
        chk("sat_neg_row9", VW'(outputVector[9*BW +: BW]), VW'(18'h20000));

        fill(0, 0);
        wmat[0][0] = 1;
        xvec[0]    = 1024;
        run_and_check("round_half_up");
        chk("round_half_up_row0", VW'(outputVector[0 +: BW]), VW'(1));
        xvec[0] = 1023;
        run_and_check("round_below_half");

        fill_identity();
        run_and_check("identity");

        for (int r = 0; r < NROW; r++)
            for (int c = 0; c < NCOL; c++) wmat[r][c] = int'($urandom_range(0, 8191)) - 4096;
        for (int c = 0; c < NCOL; c++) xvec[c] = int'($urandom_range(0, 8191)) - 4096;
        run_and_check("random");

        // Back-to-back: start held across DONE, then a stray pulse mid-CALC.
        fill_identity();
        sbq.push_back(model());
        sbq.push_back(model());
        start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dataReady && n < 200);
        chk("b2b_latency1", VW'(n), VW'(LAT));
        e = sbq.pop_front();
        chk("b2b_vector1", outputVector, e.vec);
        @(negedge clk);
        chk("b2b_restart", VW'({busy, dataReady}), VW'(2'b10));
        chk("b2b_restart_addr", VW'({rowMux, colAddress}), '0);
        start = 1'b0;
        n = 1;
        do begin
            @(negedge clk);
            n++;
            start = (n == 30);
        end while (!dataReady && n < 200);
        start = 1'b0;
        chk("b2b_latency2", VW'(n), VW'(LAT));
        e = sbq.pop_front();
        chk("b2b_vector2", outputVector, e.vec);
        chk("b2b_overflow2", VW'(overflow), VW'(e.ovf));
        @(negedge clk);
        d0 = dr_cnt;
        repeat (100) @(negedge clk);
        chk("b2b_no_extra_run", VW'(dr_cnt - d0), '0);
        chk("b2b_idle", VW'(busy), '0);

        // Reset during CALC cycle 30.
        fill(2048, 2048);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        chk("midreset_busy_before", VW'(busy), VW'(1));
        reset = 1'b0;
        #1;
        chk("midreset_vector", outputVector, '0);
        chk("midreset_flags", VW'({busy, dataReady, overflow}), '0);
        @(negedge clk);
        reset = 1'b1;
        d0 = dr_cnt;
        repeat (100) @(negedge clk);
        chk("midreset_no_ready", VW'(dr_cnt - d0), '0);
        chk("midreset_idle", VW'({busy, rowMux, colAddress}), '0);
        chk("midreset_vector_held", outputVector, '0);

        run_and_check("recover_ones");

`ifdef MVM_BIAS_ADD_EN
        for (int r = 0; r < NROW; r++) bvec[r] = 4096;
        run_and_check("bias_ones");
        chk("bias_row7", VW'(outputVector[7*BW +: BW]), VW'(36864));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
